display_dec_mux: RTL and testbench

//   Parametrised multiplexed 7-segment decimal display driver; successor to the fixed two-value/3-digit scanner.

---
 rtl/display_dec_mux.sv | 219 +++++++++++++++++++++
 tb/tb_display_dec_mux.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_dec_mux.sv
// Multiplexed 7-segment decimal display driver: NCH binary values -> BCD -> scanned digit/label glyphs.
// Latency: load accept to done = NCH*W+1 clk; new digits appear from the next scanned position after commit.
// Backpressure: load is accepted only while busy=0; a load during busy is dropped (no queueing).
//
// Ports:
//   clk   system clock           rst   async reset, active-low
//   vals  NCH packed values      load  conversion request
//   busy  conversion running     done  1-clk pulse on commit
//   sseg  segments a..g (0=on)   an    position enables, one-hot-low
//   tick  1-clk refresh strobe
module display_dec_mux #(
    parameter int NCH      = 2,
    parameter int W        = 8,
    parameter int NDIG     = 3,
    parameter int DIV_BITS = 16,
    parameter int BLANK_LZ = 1,
    localparam int NPOS    = NCH * (NDIG + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*W-1:0]  vals,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic [0:6]        sseg,
    output logic [NPOS-1:0]   an,
    output logic              tick
);

    localparam int BW  = NDIG * 4;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BCW = $clog2(W + 1);
    localparam int PW  = $clog2(NPOS);

    localparam longint unsigned MAX_VAL   = (64'd1 << W) - 64'd1;
    localparam longint unsigned DEC_RANGE = 64'd10 ** NDIG;

    generate
        if (NCH < 1 || NCH > 5) begin : g_bad_nch
            $error("display_dec_mux: NCH must be in 1..5");
        end
        if (DEC_RANGE <= MAX_VAL) begin : g_bad_ndig
            $error("display_dec_mux: NDIG digits cannot hold 2**W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Refresh prescaler
    // ------------------------------------------------------------------
    logic [DIV_BITS-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = &div_cnt;

    // ------------------------------------------------------------------
    // Conversion: double-dabble, one bit per clk, channel by channel
    // ------------------------------------------------------------------
    state_t                       state;
    logic [NCH-1:0][W-1:0]        snap;
    logic [W-1:0]                 sr;
    logic [BW-1:0]                bcd;
    logic [CHW-1:0]               ch;
    logic [BCW-1:0]               bcnt;
    logic [NCH-1:0][BW-1:0]       shadow;
    logic [NCH-1:0][BW-1:0]       disp;

    logic [W-1:0]                 cur;
    logic [BW-1:0]                bcd_adj;
    logic [BW-1:0]                bcd_nx;

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int d = 0; d < NDIG; d++) begin
            if (b[d*4 +: 4] >= 4'd5) begin
                r[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // The first bit of each channel comes straight from the snapshot so the
    // shift register never needs a separate reload cycle between channels.
    assign cur     = (bcnt == '0) ? snap[ch] : sr;
    assign bcd_adj = add3(bcd);
    assign bcd_nx  = (bcd_adj << 1) | BW'(cur[W-1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            snap   <= '0;
            sr     <= '0;
            bcd    <= '0;
            ch     <= '0;
            bcnt   <= '0;
            shadow <= '0;
            disp   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        snap  <= vals;
                        bcd   <= '0;
                        ch    <= '0;
                        bcnt  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bcnt == BCW'(W - 1)) begin
                        shadow[ch] <= bcd_nx;
                        bcd        <= '0;
                        bcnt       <= '0;
                        if (ch == CHW'(NCH - 1)) begin
                            done  <= 1'b1;
                            state <= COMMIT;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end else begin
                        bcd  <= bcd_nx;
                        sr   <= cur << 1;
                        bcnt <= bcnt + 1'b1;
                    end
                end
                COMMIT: begin
                    // All channels switch together; the scanner only samples
                    // disp on a tick, so one position never shows mixed data.
                    disp  <= shadow;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan: glyph code for the current position
    // ------------------------------------------------------------------
    logic [PW-1:0] idx;
    logic [3:0]    code;

    always_comb begin
        code = 4'hF;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k <= NDIG; k++) begin
                if (idx == PW'(c * (NDIG + 1) + k)) begin
                    if (k == NDIG) begin
                        code = 4'(10 + c);
                    end else if ((BLANK_LZ != 0) && (k != 0) &&
                                 ((disp[c] >> (4 * k)) == '0)) begin
                        // this digit and everything above it are zero
                        code = 4'hF;
                    end else begin
                        code = disp[c][k*4 +: 4];
                    end
                end
            end
        end
    end

    function automatic logic [0:6] seg7(input logic [3:0] g);
        logic [0:6] on;     // active-high a..g
        case (g)
            4'h0: on = 7'b1111110;
            4'h1: on = 7'b0110000;
            4'h2: on = 7'b1101101;
            4'h3: on = 7'b1111001;
            4'h4: on = 7'b0110011;
            4'h5: on = 7'b1011011;
            4'h6: on = 7'b1011111;
            4'h7: on = 7'b1110000;
            4'h8: on = 7'b1111111;
            4'h9: on = 7'b1111011;
            4'hA: on = 7'b1110111;
            4'hB: on = 7'b0011111;
            4'hC: on = 7'b1001110;
            4'hD: on = 7'b0111101;
            4'hE: on = 7'b1001111;
            default: on = 7'b0000000;
        endcase
        return ~on;
    endfunction

    // The tick shows the current index and then advances it, so the first
    // tick after reset lights position 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            an   <= '1;
            sseg <= '1;
        end else if (tick) begin
            an   <= ~(NPOS'(1) << idx);
            sseg <= seg7(code);
            idx  <= (idx == PW'(NPOS - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_display_dec_mux.sv
module tb_display_dec_mux;

    localparam int NCH  = 2;
    localparam int W    = 8;
    localparam int NDIG = 3;
    localparam int NPOS = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*W-1:0]  vals;
    logic              load;
    logic              busy, done, tick;
    logic [0:6]        sseg;
    logic [NPOS-1:0]   an;
    logic              busy_nb, done_nb, tick_nb;
    logic [0:6]        sseg_nb;
    logic [NPOS-1:0]   an_nb;

    always #5 clk = ~clk;

    display_dec_mux #(.NCH(NCH), .W(W), .NDIG(NDIG), .DIV_BITS(2), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .vals(vals), .load(load),
        .busy(busy), .done(done), .sseg(sseg), .an(an), .tick(tick)
    );

    display_dec_mux #(.NCH(NCH), .W(W), .NDIG(NDIG), .DIV_BITS(2), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .vals(vals), .load(load),
        .busy(busy_nb), .done(done_nb), .sseg(sseg_nb), .an(an_nb), .tick(tick_nb)
    );

    // active-low segment patterns, bit order a..g, codes 0-9, A b C d E, blank
    logic [6:0] seg_tab [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h7F
    };

    int n_chk  = 0;
    int n_fail = 0;
    int done_pulses = 0;

    always @(negedge clk) if (done === 1'b1) done_pulses++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL tick_timeout: no tick within 16 clk");
        end
    endtask

    function automatic int pos_of(input logic [7:0] a);
        for (int p = 0; p < NPOS; p++) begin
            if (a === ~(8'd1 << p)) return p;
        end
        return -1;
    endfunction

    // Walk one full scan and check every position; exp nibble p = glyph code at position p.
    task automatic scan_check(input string name, input logic [31:0] exp, input logic [31:0] exp_nb);
        logic [7:0] seen;
        bit         ok;
        int         p;
        seen = '0;
        for (int t = 0; t < NPOS; t++) begin
            wait_tick(ok);
            if (!ok) return;
            @(negedge clk);
            p = pos_of(an);
            chk($sformatf("%s_an_onehot", name), 32'(p >= 0), 32'd1);
            if (p >= 0) begin
                seen[p] = 1'b1;
                chk($sformatf("%s_sseg_p%0d", name, p), 32'(sseg), 32'(seg_tab[exp[p*4 +: 4]]));
                chk($sformatf("%s_nb_sseg_p%0d", name, p), 32'(sseg_nb), 32'(seg_tab[exp_nb[p*4 +: 4]]));
            end
        end
        chk($sformatf("%s_all_pos", name), 32'(seen), 32'hFF);
    endtask

    // Load v, optionally fire a second load at busy-cycle glitch_at, check busy/done timing.
    task automatic do_load(input logic [15:0] v, input int glitch_at, input string name);
        int busy_cnt, done_cnt, done_at;
        @(negedge clk);
        vals = v;
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= 40; i++) begin
            if (glitch_at > 0 && i == glitch_at) begin
                load = 1'b1;
                vals = ~v;
            end
            if (glitch_at > 0 && i == glitch_at + 1) load = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            @(negedge clk);
        end
        chk({name, "_busy_len"}, busy_cnt, 17);
        chk({name, "_done_at"}, done_at, 17);
        chk({name, "_done_cnt"}, done_cnt, 1);
    endtask

    // Reference: decimal digits by /10 and %10, blanking applied per channel.
    function automatic logic [15:0] ch_codes(input int a, input bit blz, input logic [3:0] label);
        logic [3:0] h, t, u;
        h = 4'(a / 100);
        t = 4'((a / 10) % 10);
        u = 4'(a % 10);
        if (blz && a < 100) h = 4'hF;
        if (blz && a < 10)  t = 4'hF;
        return {label, h, t, u};
    endfunction

    typedef struct {
        logic [15:0] v;
        int          glitch;
        logic [31:0] exp;
        logic [31:0] exp_nb;
    } vec_t;

    vec_t       tbl [5];
    logic [7:0] walk [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    logic       bh [1:20];
    bit         ok;
    int         base;

    initial begin
        // {ch1,ch0} ; glitch cycle ; codes pos7..pos0 (blank LZ) ; codes (no blanking)
        tbl[0] = '{16'h07FF, 0, 32'hBFF7_A255, 32'hB007_A255};   // 255 / 7
        tbl[1] = '{16'h2D09, 5, 32'hBF45_AFF9, 32'hB045_A009};   // 9 / 45, extra load ignored
        tbl[2] = '{16'h0064, 0, 32'hBFF0_A100, 32'hB000_A100};   // 100 / 0
        tbl[3] = '{16'hC80A, 0, 32'hB200_AF10, 32'hB200_A010};   // 10 / 200
        tbl[4] = '{16'h6300, 0, 32'hBF99_AFF0, 32'hB099_A000};   // 0 / 99

        rst  = 1'b0;
        vals = '0;
        load = 1'b0;
        #12;
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_sseg", 32'(sseg), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // scan walk from reset, including the wrap back to position 0
        for (int t = 0; t < 9; t++) begin
            wait_tick(ok);
            if (ok) begin
                @(negedge clk);
                chk($sformatf("walk_%0d", t), 32'(an), 32'(walk[t]));
            end
        end

        scan_check("reset_disp", 32'hBFF0_AFF0, 32'hB000_A000);

        for (int i = 0; i < 5; i++) begin
            do_load(tbl[i].v, tbl[i].glitch, $sformatf("vec%0d", i));
            scan_check($sformatf("vec%0d", i), tbl[i].exp, tbl[i].exp_nb);
        end

        // load held high: busy drops for exactly one clk, then a new conversion starts
        @(negedge clk);
        vals = 16'h0102;
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 1; i <= 20; i++) begin
            bh[i] = busy;
            @(negedge clk);
        end
        load = 1'b0;
        chk("hold_busy17", 32'(bh[17]), 32'd1);
        chk("hold_busy18", 32'(bh[18]), 32'd0);
        chk("hold_busy19", 32'(bh[19]), 32'd1);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        chk("hold_idle", 32'(busy), 32'd0);
        scan_check("hold", 32'hBFF1_AFF2, 32'hB001_A002);

        // reset in the middle of a conversion
        @(negedge clk);
        vals = 16'h1234;
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_an", 32'(an), 32'hFF);
        chk("mid_rst_sseg", 32'(sseg), 32'h7F);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        base = done_pulses;
        wait_tick(ok);
        if (ok) begin
            @(negedge clk);
            chk("mid_rst_first_an", 32'(an), 32'hFE);
        end
        scan_check("mid_rst_disp", 32'hBFF0_AFF0, 32'hB000_A000);
        chk("mid_rst_no_done", done_pulses - base, 0);
        chk("mid_rst_busy_after", 32'(busy), 32'd0);

        // every 8-bit value on ch0, complement on ch1
        for (int v = 0; v < 256; v++) begin
            do_load({8'(255 - v), 8'(v)}, 0, "exh");
            scan_check($sformatf("exh%0d", v),
                       {ch_codes(255 - v, 1'b1, 4'hB), ch_codes(v, 1'b1, 4'hA)},
                       {ch_codes(255 - v, 1'b0, 4'hB), ch_codes(v, 1'b0, 4'hA)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
